cache_line_fill: RTL and testbench

// - Miss-refill engine between the cache and the main-memory model.
// - On a miss, the cache requests a line fill. This block reads WORDS_PER_LINE consecutive

---
 rtl/cache_line_fill.sv | 71 +++++++
 tb/tb_cache_line_fill.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// cache_line_fill: reads one cache line of consecutive words from fixed-latency memory and returns it with a done pulse
module cache_line_fill #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W = 28,
  parameter int RAM_ADDR_W = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               fill_req,
  input  logic [ADDR_W-1:0]                  fill_addr,
  output logic                               fill_busy,
  output logic                               fill_done,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   fill_line,
  output logic [TAG_W-1:0]                   fill_tag,
  output logic [RAM_ADDR_W-1:0]              RAM_address,
  output logic                               mem_rd_en,
  input  logic [WORD_W-1:0]                  main_memory_data
);
  localparam int LW = $clog2(WORDS_PER_LINE);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic accept, last_issue, cap, cap_last;
  logic [MEM_LATENCY-1:0] pv;
  logic [LW-1:0] pi [MEM_LATENCY];
  assign accept = fill_req && (state == IDLE || state == DONE);
  assign last_issue = RAM_address[LW-1:0] == LW'(WORDS_PER_LINE - 1);
  assign cap = pv[MEM_LATENCY-1];
  assign cap_last = cap && pi[MEM_LATENCY-1] == LW'(WORDS_PER_LINE - 1);
  assign fill_busy = state == ISSUE || state == DRAIN;
  assign fill_done = state == DONE;
  // next state: issue one word per cycle, then wait for the last word to come back
  always_comb begin
    state_nx = accept ? ISSUE
             : state == ISSUE ? (last_issue ? DRAIN : ISSUE)
             : state == DRAIN ? (cap_last ? DONE : DRAIN)
             : IDLE;
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // address sequencing, valid pipe and line assembly; the offset increments only within the line
  always_ff @(posedge clock) begin
    if (reset) begin
      RAM_address <= '0;
      mem_rd_en <= 1'b0;
      fill_tag <= '0;
      fill_line <= '0;
      pv <= '0;
    end else begin
      mem_rd_en <= state_nx == ISSUE;
      if (accept) begin
        RAM_address <= RAM_ADDR_W'(fill_addr & ~ADDR_W'(WORDS_PER_LINE - 1));
        fill_tag <= fill_addr[ADDR_W-1 -: TAG_W];
      end else if (state == ISSUE && !last_issue)
        RAM_address <= {RAM_address[RAM_ADDR_W-1:LW], RAM_address[LW-1:0] + LW'(1)};
      pv[0] <= mem_rd_en;
      for (int i = 1; i < MEM_LATENCY; i++) pv[i] <= pv[i-1];
      if (cap) fill_line[pi[MEM_LATENCY-1]*WORD_W +: WORD_W] <= main_memory_data;
    end
  end
  // word index travels alongside the valid bit; it is only meaningful where the valid bit is set
  always_ff @(posedge clock) begin
    pi[0] <= RAM_address[LW-1:0];
    for (int i = 1; i < MEM_LATENCY; i++) pi[i] <= pi[i-1];
  end
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: table vectors plus corner sequences, checked through an address/fill scoreboard
module tb_cache_line_fill;
  localparam int N = 4;
  localparam int L = 1;
  typedef struct {logic [63:0] addr; int cyc;} rd_t;
  typedef struct {logic [255:0] line; logic [27:0] tag; int cyc;} fill_t;
  typedef struct {logic [31:0] addr; logic [27:0] tag; logic [255:0] line;} vec_t;
  logic clock = 0, reset = 1, fill_req = 0, req2 = 0;
  logic [31:0] fill_addr = 0, addr2 = 0;
  logic fill_busy, fill_done, mem_rd_en, busy2, done2, en2;
  logic [255:0] fill_line, line2;
  logic [27:0] fill_tag, tag2;
  logic [63:0] RAM_address, ra2, mem_data, m2a, m2;
  int cyc = 0, nvec = 0, nerr = 0, e0, t;
  rd_t rd_q[$], r;
  fill_t fill_q[$], f;
  vec_t vecs[4];

  cache_line_fill u1 (.clock(clock), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_line(fill_line), .fill_tag(fill_tag),
    .RAM_address(RAM_address), .mem_rd_en(mem_rd_en), .main_memory_data(mem_data));
  cache_line_fill #(.MEM_LATENCY(2)) u2 (.clock(clock), .reset(reset), .fill_req(req2), .fill_addr(addr2),
    .fill_busy(busy2), .fill_done(done2), .fill_line(line2), .fill_tag(tag2),
    .RAM_address(ra2), .mem_rd_en(en2), .main_memory_data(m2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    mem_data <= RAM_address * RAM_address;
    m2a <= ra2 * ra2;
    m2 <= m2a;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic push_rd(input logic [31:0] addr, input int start, input int cnt);
    logic [63:0] base = {32'd0, addr & ~32'd3};
    for (int k = 0; k < cnt; k++) rd_q.push_back('{base + 64'(k), start + k});
  endtask

  task automatic push_fill(input logic [31:0] addr, input int start, input logic [255:0] line, input logic [27:0] tag);
    push_rd(addr, start, N);
    fill_q.push_back('{line, tag, start + N + L});
  endtask

  task automatic wait_drain();
    t = 0;
    while ((rd_q.size() != 0 || fill_q.size() != 0) && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (rd_q.size() != 0 || fill_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d reads and %0d fills still outstanding", rd_q.size(), fill_q.size());
      rd_q.delete();
      fill_q.delete();
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, fill_busy, 0);
    chk({name, "_done"}, fill_done, 0);
    chk({name, "_line"}, fill_line, 0);
    chk({name, "_tag"}, fill_tag, 0);
    chk({name, "_addr"}, RAM_address, 0);
    chk({name, "_rden"}, mem_rd_en, 0);
  endtask

  always @(negedge clock) begin
    if (mem_rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_rd: address 0x%0h issued, none expected", RAM_address);
      end else begin
        r = rd_q.pop_front();
        chk("rd_addr", RAM_address, r.addr);
        chk("rd_cycle", cyc, r.cyc);
      end
    end
    if (fill_done === 1'b1) begin
      if (fill_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_done: fill_done at cycle %0d, none expected", cyc);
      end else begin
        f = fill_q.pop_front();
        chk("done_line", fill_line, f.line);
        chk("done_tag", fill_tag, f.tag);
        chk("done_cycle", cyc, f.cyc);
        chk("done_busy", fill_busy, 0);
      end
    end
  end

  initial begin
    vecs[0] = '{32'd1023, 28'd63, mk(1040400, 1042441, 1044484, 1046529)};
    vecs[1] = '{32'd5, 28'd0, mk(16, 25, 36, 49)};
    vecs[2] = '{32'h100, 28'd16, mk(65536, 66049, 66564, 67081)};
    vecs[3] = '{32'hFFFFFFFF, 28'hFFFFFFF, mk(64'hFFFFFFFC * 64'hFFFFFFFC, 64'hFFFFFFFD * 64'hFFFFFFFD,
                                               64'hFFFFFFFE * 64'hFFFFFFFE, 64'hFFFFFFFF * 64'hFFFFFFFF)};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      fill_addr = vecs[i].addr;
      fill_req = 1;
      e0 = cyc + 1;
      push_fill(vecs[i].addr, e0, vecs[i].line, vecs[i].tag);
      @(negedge clock);
      fill_req = 0;
      wait_drain();
    end
    fill_addr = 0;
    fill_req = 1;
    e0 = cyc + 1;
    push_fill(0, e0, mk(0, 1, 4, 9), 0);
    @(negedge clock);
    fill_req = 0;
    @(negedge clock);
    fill_addr = 8;
    fill_req = 1;
    chk("ignored_busy", fill_busy, 1);
    @(negedge clock);
    fill_req = 0;
    wait_drain();
    repeat (8) @(negedge clock);
    fill_addr = 0;
    fill_req = 1;
    e0 = cyc + 1;
    push_fill(0, e0, mk(0, 1, 4, 9), 0);
    @(negedge clock);
    fill_addr = 4;
    t = 0;
    while (fill_done !== 1'b1 && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (fill_done !== 1'b1) begin
      nvec++;
      nerr++;
      $display("FAIL b2b_timeout: no fill_done within %0d cycles", t);
    end
    push_fill(4, cyc + 1, mk(16, 25, 36, 49), 0);
    @(negedge clock);
    fill_req = 0;
    wait_drain();
    fill_addr = 512;
    fill_req = 1;
    e0 = cyc + 1;
    push_rd(512, e0, 3);
    @(negedge clock);
    fill_req = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk_zero("midrst");
    reset = 0;
    repeat (10) @(negedge clock);
    chk("midrst_rd_q", rd_q.size(), 0);
    fill_addr = 2;
    fill_req = 1;
    e0 = cyc + 1;
    push_fill(2, e0, mk(0, 1, 4, 9), 0);
    @(negedge clock);
    fill_req = 0;
    wait_drain();
    addr2 = 7;
    req2 = 1;
    e0 = cyc + 1;
    @(negedge clock);
    req2 = 0;
    t = 0;
    while (done2 !== 1'b1 && t < 40) begin
      @(negedge clock);
      t++;
    end
    chk("lat2_done", done2, 1);
    chk("lat2_cycle", cyc, e0 + N + 2);
    chk("lat2_line", line2, mk(16, 25, 36, 49));
    chk("lat2_tag", tag2, 0);
    @(negedge clock);
    chk("lat2_pulse", done2, 0);
    chk("end_rd_q", rd_q.size(), 0);
    chk("end_fill_q", fill_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
